// File: rtl/lambda_column_feeder.sv
// Feeds systematic message columns to lambda_gap_evaluate: each accepted block is
// cyclically shifted per core row and strobed out one cycle later. Optional abort: LAMBDA_FEEDER_ABORT_EN.
module lambda_column_feeder #(
  parameter int MAX_ZC   = 384,
  parameter int GAP_ROWS = 4,
  parameter int SHIFT_W  = 10
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               bg,
  input  logic [8:0]                         zc,
  input  logic                               msg_valid,
  input  logic [MAX_ZC-1:0]                  msg_block,
  output logic                               msg_ready,
  output logic [4:0]                         shift_rd_col,
  input  logic [GAP_ROWS-1:0][SHIFT_W-1:0]   shift_vals,
  output logic [GAP_ROWS-1:0][MAX_ZC-1:0]    shifted_msg_block,
  output logic                               lambda_eval_en,
  input  logic                               gap_eval_done,
  output logic                               busy,
  output logic                               frame_done,
`ifdef LAMBDA_FEEDER_ABORT_EN
  input  logic                               abort,
`endif
  output logic                               shift_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FEED     = 2'd1,
    WAIT_GAP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]                      col_cnt;
  logic                            bg_q;
  logic [8:0]                      zc_q;
  logic                            gap_prev;
  logic                            abort_req;
  logic                            handshake;
  logic                            gap_rise;
  logic                            frame_start;
  logic                            frame_end;
  logic [4:0]                      last_col;
  logic [MAX_ZC-1:0]               zmask;
  logic [MAX_ZC-1:0]               msg_m;
  logic [GAP_ROWS-1:0][MAX_ZC-1:0] rot_d;
  logic [GAP_ROWS-1:0]             row_err;
  int                              sv;
  logic [8:0]                      sh_a;
  logic [8:0]                      sh_b;

`ifdef LAMBDA_FEEDER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign shift_rd_col = col_cnt;
  assign msg_ready    = (state_q == FEED) & ~abort_req;
  assign handshake    = msg_valid & msg_ready;
  assign gap_rise     = gap_eval_done & ~gap_prev;
  assign last_col     = bg_q ? 5'd9 : 5'd21;

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FEED;
          frame_start = 1'b1;
        end
      end
      FEED: begin
        if (handshake && (col_cnt == last_col)) state_d = WAIT_GAP;
      end
      WAIT_GAP: begin
        if (gap_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition, including a frame completing this cycle.
    if (abort_req) begin
      state_d     = IDLE;
      frame_start = 1'b0;
      frame_end   = 1'b0;
    end
  end

  always_comb begin
    zmask = '0;
    for (int unsigned j = 0; j < MAX_ZC; j++) begin
      zmask[j] = (j < 32'(zc_q));
    end
  end

  assign msg_m = msg_block & zmask;

  // Rotation within zc bits: (m >> s) supplies out[j] for j+s < zc, the left
  // shift by zc-s supplies the wrapped part; the mask clears bits >= zc.
  always_comb begin
    rot_d   = '0;
    row_err = '0;
    sv      = 0;
    sh_a    = '0;
    sh_b    = '0;
    for (int unsigned r = 0; r < GAP_ROWS; r++) begin
      sv   = int'($signed(shift_vals[r]));
      sh_a = '0;
      sh_b = '0;
      if (sv == -1) begin
        rot_d[r] = '0;
      end else if ((sv < 0) || (sv >= int'(zc_q))) begin
        rot_d[r]   = '0;
        row_err[r] = 1'b1;
      end else begin
        sh_a     = sv[8:0];
        sh_b     = zc_q - sh_a;
        rot_d[r] = ((msg_m >> sh_a) | (msg_m << sh_b)) & zmask;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      col_cnt           <= '0;
      bg_q              <= 1'b0;
      zc_q              <= '0;
      gap_prev          <= 1'b0;
      lambda_eval_en    <= 1'b0;
      frame_done        <= 1'b0;
      shift_err         <= 1'b0;
      shifted_msg_block <= '0;
    end else begin
      state_q        <= state_d;
      gap_prev       <= gap_eval_done;
      lambda_eval_en <= handshake;
      frame_done     <= frame_end;
      if (frame_start) begin
        col_cnt   <= '0;
        shift_err <= 1'b0;
        bg_q      <= bg;
        zc_q      <= (zc > 9'(MAX_ZC)) ? 9'(MAX_ZC) : zc;
      end else if (abort_req) begin
        col_cnt <= '0;
      end else if (handshake) begin
        col_cnt           <= col_cnt + 5'd1;
        shifted_msg_block <= rot_d;
        if (|row_err) shift_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lambda_column_feeder.sv
// Scoreboard bench for lambda_column_feeder: driver pushes expected shifted
// columns at each handshake, a negedge monitor pops and compares every strobe.
module tb_lambda_column_feeder;

  localparam int MZ = 384;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                bg_i = 1'b0;
  logic [8:0]          zc_i = '0;
  logic                msg_valid = 1'b0;
  logic [MZ-1:0]       msg_block = '0;
  logic                msg_ready;
  logic [4:0]          shift_rd_col;
  logic [3:0][9:0]     shift_vals;
  logic [3:0][MZ-1:0]  shifted;
  logic                lambda_eval_en;
  logic                gap = 1'b0;
  logic                busy;
  logic                frame_done;
  logic                shift_err;
`ifdef LAMBDA_FEEDER_ABORT_EN
  logic                abort = 1'b0;
`endif

  lambda_column_feeder #(.MAX_ZC(MZ), .GAP_ROWS(4), .SHIFT_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bg(bg_i), .zc(zc_i),
    .msg_valid(msg_valid), .msg_block(msg_block), .msg_ready(msg_ready),
    .shift_rd_col(shift_rd_col), .shift_vals(shift_vals),
    .shifted_msg_block(shifted), .lambda_eval_en(lambda_eval_en),
    .gap_eval_done(gap), .busy(busy), .frame_done(frame_done),
`ifdef LAMBDA_FEEDER_ABORT_EN
    .abort(abort),
`endif
    .shift_err(shift_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned         stamp;
    logic [3:0][MZ-1:0]  data;
  } exp_t;

  exp_t        q[$];
  int          rom [0:21][0:3];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          strobes = 0;
  int          fd_count = 0;
  int          cur_zc;
  int          ncols;
  logic        err_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Stands in for the shift ROM, indexed by the DUT's requested column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      shift_vals[r] = '0;
      if (shift_rd_col < 5'd22) shift_vals[r] = 10'(rom[shift_rd_col][r]);
    end
  end

  task automatic checkw(input string name, input logic [MZ-1:0] act, input logic [MZ-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [MZ-1:0] model_row(input logic [MZ-1:0] m, input int s, input int z);
    logic [MZ-1:0] o;
    o = '0;
    if (s >= 0 && s < z)
      for (int j = 0; j < z; j++) o[j] = m[(j + s) % z];
    return o;
  endfunction

  always @(negedge clk) begin
    if (reset_n && frame_done) fd_count++;
    if (reset_n && lambda_eval_en) begin
      strobes++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        checkn("strobe_latency", int'(cyc), int'(e.stamp));
        for (int r = 0; r < 4; r++) checkw($sformatf("row%0d", r), shifted[r], e.data[r]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check1({tag, "_msg_ready"}, msg_ready, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_eval_en"}, lambda_eval_en, 1'b0);
    check1({tag, "_frame_done"}, frame_done, 1'b0);
    check1({tag, "_shift_err"}, shift_err, 1'b0);
    for (int r = 0; r < 4; r++) checkw($sformatf("%s_row%0d", tag, r), shifted[r], '0);
  endtask

  function automatic int rand_shift(input int z, input bit allow_err);
    int p;
    p = int'($urandom % 16);
    if (p == 0) return -1;
    if (allow_err && p == 1) return ($urandom % 2) ? z + int'($urandom_range(0, 511 - z)) : -2 - int'($urandom % 100);
    return int'($urandom % z);
  endfunction

  task automatic fill_rom(input int z, input bit allow_err);
    for (int c = 0; c < 22; c++)
      for (int r = 0; r < 4; r++) rom[c][r] = rand_shift(z, allow_err);
  endtask

  task automatic start_frame(input logic b, input int z);
    @(posedge clk); #1;
    start = 1'b1; bg_i = b; zc_i = 9'(z);
    cur_zc = z; ncols = b ? 10 : 22; err_exp = 1'b0; strobes = 0;
    @(posedge clk); #1;
    start = 1'b0;
    bg_i = 1'($urandom);
    zc_i = 9'($urandom);
    check1("start_busy", busy, 1'b1);
    check1("start_err_clear", shift_err, 1'b0);
  endtask

  // mode: 0 back-to-back, 1 alternate cycles, 2 random valid
  task automatic feed(input int mode, input int target, input bit use_fixed, input logic [MZ-1:0] fixed);
    int acc = 0;
    int guard = 0;
    bit tog = 1'b1;
    while (acc < target && guard < 400) begin
      case (mode)
        0: msg_valid = 1'b1;
        1: begin msg_valid = tog; tog = ~tog; end
        default: msg_valid = 1'($urandom);
      endcase
      if (use_fixed) msg_block = fixed;
      else for (int k = 0; k < MZ / 32; k++) msg_block[k*32 +: 32] = $urandom;
      @(negedge clk);
      if (msg_valid && msg_ready) begin
        exp_t e;
        e.stamp = cyc + 1;
        for (int r = 0; r < 4; r++) begin
          e.data[r] = model_row(msg_block, rom[acc][r], cur_zc);
          if (rom[acc][r] != -1 && (rom[acc][r] < 0 || rom[acc][r] >= cur_zc)) err_exp = 1'b1;
        end
        q.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
      guard++;
    end
    msg_valid = 1'b0;
    checkn("feed_accepts", acc, target);
    if (target == ncols) check1("ready_drop_after_last", msg_ready, 1'b0);
  endtask

  task automatic finish_frame(input bit hold_high, input bit start_same);
    int  fd0;
    bit  got = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checkn("strobe_count", strobes, ncols);
    checkn("queue_empty", q.size(), 0);
    check1("shift_err_frame", shift_err, err_exp);
    check1("busy_wait_gap", busy, 1'b1);
    fd0 = fd_count;
    if (hold_high) begin
      repeat (5) @(negedge clk);
      #1;
      check1("stale_gap_busy", busy, 1'b1);
      checkn("stale_gap_no_done", fd_count, fd0);
    end
    @(posedge clk); #1 gap = 1'b0;
    @(posedge clk); #1 gap = 1'b1; start = start_same;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    check1("frame_done_seen", got, 1'b1);
    check1("busy_at_done", busy, 1'b0);
    start = 1'b0;
    @(negedge clk); #1;
    check1("frame_done_width", frame_done, 1'b0);
    check1("start_at_done_ignored", busy, 1'b0);
    checkn("frame_done_count", fd_count, fd0 + 1);
    check1("shift_err_sticky", shift_err, err_exp);
    gap = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MZ-1:0] one;
    one = '0;
    one[0] = 1'b1;

    #23;
    check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // BG2 zc=8, row0 shift 3, rows1-3 null
    for (int c = 0; c < 22; c++) begin
      rom[c][0] = 3; rom[c][1] = -1; rom[c][2] = -1; rom[c][3] = -1;
    end
    start_frame(1'b1, 8);
    feed(0, 10, 1'b1, one);
    finish_frame(1'b0, 1'b1);

    // BG1 zc=384 alternating valid
    fill_rom(384, 1'b0);
    start_frame(1'b0, 384);
    feed(1, 22, 1'b0, '0);
    finish_frame(1'b0, 1'b0);

    // out-of-range shift on column 4 row 2
    fill_rom(10, 1'b0);
    rom[4][2] = 12;
    start_frame(1'b1, 10);
    feed(2, 10, 1'b0, '0);
    finish_frame(1'b0, 1'b0);

    // gap_eval_done still high when entering WAIT_GAP
    gap = 1'b1;
    fill_rom(37, 1'b0);
    start_frame(1'b1, 37);
    feed(0, 10, 1'b0, '0);
    finish_frame(1'b1, 1'b0);

    // reset mid-frame after 5 columns
    fill_rom(100, 1'b0);
    start_frame(1'b1, 100);
    feed(0, 5, 1'b0, '0);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    @(negedge clk) reset_n = 1'b1;
    start_frame(1'b1, 100);
    feed(2, 10, 1'b0, '0);
    finish_frame(1'b0, 1'b0);

`ifdef LAMBDA_FEEDER_ABORT_EN
    begin
      int fd0;
      fill_rom(50, 1'b0);
      start_frame(1'b1, 50);
      feed(0, 7, 1'b0, '0);
      fd0 = fd_count;
      msg_valid = 1'b1; abort = 1'b1;
      @(negedge clk);
      check1("abort_ready_low", msg_ready, 1'b0);
      @(posedge clk); #1;
      abort = 1'b0; msg_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check1("abort_idle", busy, 1'b0);
      checkn("abort_strobes", strobes, 7);
      checkn("abort_no_done", fd_count, fd0);
    end
`endif

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      int  z;
      logic b;
      z = int'($urandom_range(2, 384));
      b = 1'($urandom);
      fill_rom(z, 1'b1);
      start_frame(b, z);
      feed(int'($urandom % 3), b ? 10 : 22, 1'b0, '0);
      finish_frame(1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lambda_column_feeder.md
Name: lambda_column_feeder

Overview:
Upstream stage of lambda_gap_evaluate. Accepts one systematic message block (Zc bits) per handshake, in column order. Cyclically shifts each block by the four core-row base-graph shift values and presents the result as shifted_msg_block with a one-cycle lambda_eval_en strobe, exactly max-column-count times per frame. Waits for gap_eval_done before accepting the next frame.

Parameters:
MAX_ZC, 384, maximum lifting size and vector width
GAP_ROWS, 4, core (gap) rows fed per column; matches GAP_COLS_COUNT
SHIFT_W, 10, signed shift-value width; -1 encodes a null entry

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
start  in  1  begin frame; sampled only in IDLE
bg  in  1  0=BG1 (22 msg cols), 1=BG2 (10 msg cols); latched at start
zc  in  9  lifting size 2..384; latched at start
msg_valid  in  1  msg_block valid
msg_block  in  MAX_ZC  message column; bits [zc-1:0] used
msg_ready  out  1  feeder accepts msg_block
shift_rd_col  out  5  column index driven to the shift ROM (combinational lookup)
shift_vals  in  GAP_ROWS x SHIFT_W  signed shifts for rows 0..3 at shift_rd_col
shifted_msg_block  out  GAP_ROWS x MAX_ZC  shifted column per core row
lambda_eval_en  out  1  one-cycle strobe; shifted_msg_block valid
gap_eval_done  in  1  from lambda_gap_evaluate; level, may stay high
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame completion
shift_err  out  1  sticky per frame; a shift value >= zc was seen

Behaviour:
- Reset (async): state IDLE, col_cnt=0. All outputs 0, including shifted_msg_block, lambda_eval_en, msg_ready, frame_done, shift_err.
- Also reset internally: registered gap_eval_done sample, latched bg/zc.
- FSM IDLE -> FEED on start. FEED -> WAIT_GAP on last column accepted. WAIT_GAP -> IDLE on rising edge of gap_eval_done.
- Rising-edge detection uses a registered previous sample of gap_eval_done.
- start in FEED/WAIT_GAP is ignored.
- On IDLE->FEED: clear col_cnt and shift_err; latch bg and zc.
- msg_ready = (state==FEED).
- Handshake = msg_valid & msg_ready. Sample msg_block and shift_vals in the same cycle; shift_rd_col = col_cnt.
- Latency: 1 cycle. shifted_msg_block and lambda_eval_en are registered; lambda_eval_en is high the cycle after each handshake.
- No handshake in a cycle: lambda_eval_en=0 and shifted_msg_block holds its value. Bubbles are allowed; downstream counts strobes.
- Per row r, with s = shift_vals[r]:
  - s = -1: output all zeros.
  - 0 <= s < zc: out[j] = in[(j+s) mod zc] for j < zc; out[j] = 0 for j >= zc.
  - s >= zc or s < -1: output zeros, set shift_err.
- col_cnt increments per handshake. Last column is col_cnt = 21 (BG1) or 9 (BG2).
- The last handshake moves to WAIT_GAP; msg_ready drops in the next cycle.
- Exactly 22 (BG1) or 10 (BG2) strobes per frame, never more.
- frame_done pulses 1 cycle on the WAIT_GAP->IDLE transition.
- start in the same cycle as that transition is ignored; start is accepted from IDLE on the next cycle.
- gap_eval_done already high on entering WAIT_GAP does not count; the block waits for a fresh 0->1 edge.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The partial frame is discarded.
- zc changes mid-frame have no effect (latched value used).

Optional Feature:
LAMBDA_FEEDER_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in any state forces IDLE next cycle, clears col_cnt, and forces lambda_eval_en=0 and msg_ready=0 that cycle. No frame_done pulse. Abort beats a same-cycle handshake: the handshake is not accepted.
- Undefined: no abort port; the only exits from FEED/WAIT_GAP are normal completion or reset_n.

Test Plan:
- BG2, zc=8, 10 back-to-back columns, msg_block=8'h01, row0 shift=3, rows1-3 = -1 -> 10 strobes; row0 = 8'h20 each strobe, rows1-3 = 0; msg_ready low after 10th accept.
- BG1, zc=384, msg_valid toggled every other cycle -> exactly 22 strobes, each 1 cycle after its handshake; none during bubbles.
- zc=10, shift=12 on column 4 row 2 -> that row outputs 0; shift_err=1 until next start; other rows are correct.
- WAIT_GAP with gap_eval_done held high from the prior frame -> stays in WAIT_GAP. Drop gap_eval_done then raise it -> frame_done pulses once; busy=0 next cycle.
- reset_n asserted after 5 of 10 BG2 columns -> all outputs 0 immediately. A new start yields a full 10-strobe frame.
- (LAMBDA_FEEDER_ABORT_EN) abort at column 7 together with msg_valid -> no strobe for that column; IDLE next cycle; no frame_done.
